calc_arbiter: RTL and testbench

- Shares one calculation datapath and its sequencing controller among N requesters.
- Arbitrates requests round-robin and latches the winner's operand onto the datapath X input.
- Pulses inicio to the controller, waits for pronto, captures the result, clears the controller, and returns the result to the winner over a valid/ready response.
- Sits between the requesting client blocks and the controller/datapath pair.

---
 rtl/calc_arbiter_if.sv | 37 +++
 rtl/calc_arbiter.sv | 166 ++++++++++++++++
 tb/tb_calc_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_arbiter_if.sv
// calc_arbiter_if: bundle of requester, controller/datapath and response
// signals around calc_arbiter. The master modport is the arbiter's view; the
// slave modport is the view of the surrounding clients/controller.
interface calc_arbiter_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
);
    // A single requester still needs a 1-bit id field.
    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
    logic [N*W-1:0] req_x;
    logic [N-1:0]   grant;
    logic           busy;
    logic [W-1:0]   dp_x;
    logic           inicio;
    logic           ctrl_clr;
    logic           pronto;
    logic [W-1:0]   dp_result;
    logic           resp_valid;
    logic           resp_ready;
    logic [IDW-1:0] resp_id;
    logic [W-1:0]   resp_data;
    logic           resp_err;

    modport master (
        input  req, req_x, pronto, dp_result, resp_ready,
        output grant, busy, dp_x, inicio, ctrl_clr,
               resp_valid, resp_id, resp_data, resp_err
    );

    modport slave (
        output req, req_x, pronto, dp_result, resp_ready,
        input  grant, busy, dp_x, inicio, ctrl_clr,
               resp_valid, resp_id, resp_data, resp_err
    );
endinterface

// File: rtl/calc_arbiter.sv
// calc_arbiter: round-robin sharing of one controller/datapath pair among N
// requesters. Winner's operand goes to dp_x, inicio starts the controller,
// pronto ends the job, ctrl_clr clears the controller and the result is
// returned over a valid/ready response tagged with the winner's index.
// Optional build macro CALC_TIMEOUT_EN: abort a job after TIMEOUT cycles in
// WAIT without pronto, returning resp_err=1 and resp_data=0.
module calc_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned W       = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input logic           clk,
    input logic           rst,
    calc_arbiter_if.master bus
);
    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;

    if (N < 1 || N > 16 || TIMEOUT < 1) begin : g_bad_params
        $error("calc_arbiter: N must be 1..16 and TIMEOUT at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         state_q;
    logic [N-1:0]   grant_q;
    logic           busy_q;
    logic [W-1:0]   dp_x_q;
    logic           inicio_q;
    logic           ctrl_clr_q;
    logic           resp_valid_q;
    logic [IDW-1:0] resp_id_q;
    logic [W-1:0]   resp_data_q;
    logic [IDW-1:0] last_q;

    logic           win_vld_d;
    logic [IDW-1:0] win_id_d;
    logic [N-1:0]   win_oh_d;
    logic [W-1:0]   win_x_d;

`ifdef CALC_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt_q;
    logic          resp_err_q;
`endif

    // Round-robin search: first requester at last+1, last+2, ... modulo N.
    always_comb begin
        win_vld_d = 1'b0;
        win_id_d  = '0;
        win_oh_d  = '0;
        win_x_d   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!win_vld_d && bus.req[i] && (i == (32'(last_q) + k) % N)) begin
                    win_vld_d   = 1'b1;
                    win_id_d    = IDW'(i);
                    win_oh_d[i] = 1'b1;
                    win_x_d     = bus.req_x[i*W +: W];
                end
            end
        end
    end

    // Job sequencer with all outputs registered; inicio/ctrl_clr are pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            busy_q       <= 1'b0;
            dp_x_q       <= '0;
            inicio_q     <= 1'b0;
            ctrl_clr_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            last_q       <= IDW'(N - 1);
`ifdef CALC_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            resp_err_q   <= 1'b0;
`endif
        end else begin
            inicio_q   <= 1'b0;
            ctrl_clr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|bus.req) begin
                        busy_q  <= 1'b1;
                        state_q <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (win_vld_d) begin
                        grant_q   <= win_oh_d;
                        dp_x_q    <= win_x_d;
                        resp_id_q <= win_id_d;
                        inicio_q  <= 1'b1;
                        state_q   <= S_START;
                    end else begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_START: begin
`ifdef CALC_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // pronto is checked first so it wins in the expiry cycle.
                    if (bus.pronto) begin
                        resp_data_q  <= bus.dp_result;
                        ctrl_clr_q   <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
`ifdef CALC_TIMEOUT_EN
                        resp_err_q   <= 1'b0;
                    end else if (tmo_cnt_q == CW'(TIMEOUT - 1)) begin
                        resp_data_q  <= '0;
                        ctrl_clr_q   <= 1'b1;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    if (resp_valid_q && bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        grant_q      <= '0;
                        busy_q       <= 1'b0;
                        last_q       <= resp_id_q;
`ifdef CALC_TIMEOUT_EN
                        resp_err_q   <= 1'b0;
`endif
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.grant      = grant_q;
    assign bus.busy       = busy_q;
    assign bus.dp_x       = dp_x_q;
    assign bus.inicio     = inicio_q;
    assign bus.ctrl_clr   = ctrl_clr_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
`ifdef CALC_TIMEOUT_EN
    assign bus.resp_err   = resp_err_q;
`else
    assign bus.resp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_calc_arbiter.sv
// tb_calc_arbiter: scoreboard bench for calc_arbiter. A behavioural
// controller answers inicio with pronto after a chosen delay; a round-robin
// model predicts each response, and a negedge monitor checks responses.
module tb_calc_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;

    calc_arbiter_if #(.N(N), .W(W)) bus ();

    calc_arbiter #(.N(N), .W(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           id;
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   model_last = N - 1;
    int   cyc = 0;
    int   hs_count = 0;
    int   ini_cnt = 0;
    int   clr_cnt = 0;
    int   ready_pct = 100;
    bit   bp_hold = 0;

    // controller model state
    int   ctl_delay = -1;
    bit   active = 0;
    int   ccnt = 0;
    bit   p_set = 0;
    int   p_cyc = 0;
    int   ini_cyc = 0;
    int   clr_cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] dp_func(input logic [W-1:0] x);
        return W'(x * 5 + 3);
    endfunction

    function automatic int rr_pick(input int last, input logic [N-1:0] m);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (m[idx]) return idx;
        end
        return -1;
    endfunction

    // Monitor: compares every presented response to the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                ini_cnt = 0;
                clr_cnt = 0;
            end else begin
                if (bus.inicio || bus.ctrl_clr)
                    check("inicio_clr_exclusive", 64'(bus.inicio & bus.ctrl_clr), 0);
                if (bus.inicio) ini_cnt++;
                if (bus.ctrl_clr) clr_cnt++;
                if (bus.resp_valid) begin
                    if (expq.size() == 0) begin
                        check("resp_unexpected", 64'(bus.resp_valid), 0);
                    end else begin
                        mon_e = expq[0];
                        check("resp_id", 64'(bus.resp_id), 64'(mon_e.id));
                        check("resp_data", 64'(bus.resp_data), 64'(mon_e.data));
                        check("resp_err", 64'(bus.resp_err), 64'(mon_e.err));
                        check("resp_grant", 64'(bus.grant), 64'(1) << mon_e.id);
                        check("resp_no_inicio", 64'(bus.inicio), 0);
                        if (bus.resp_ready) begin
                            check("inicio_pulses", 64'(ini_cnt), 1);
                            check("ctrl_clr_pulses", 64'(clr_cnt), 1);
                            void'(expq.pop_front());
                            ini_cnt = 0;
                            clr_cnt = 0;
                            hs_count++;
                        end
                    end
                end
            end
        end
    end

    // Consumer: random readiness, forced low during a back-pressure hold.
    initial begin
        bus.resp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.resp_ready = bp_hold ? 1'b0 : ($urandom_range(99) < ready_pct);
        end
    end

    // Controller model: pronto after a delay, held until ctrl_clr; when idle
    // it drives spurious pronto with garbage results.
    initial begin
        bus.pronto    = 1'b0;
        bus.dp_result = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                active     = 0;
                p_set      = 0;
                bus.pronto = 1'b0;
            end else if (active && bus.ctrl_clr) begin
                if (p_set) begin
                    check("pronto_to_clr", 64'(cyc - p_cyc), 1);
                    check("pronto_to_valid", 64'(bus.resp_valid), 1);
                end
                clr_cyc    = cyc;
                active     = 0;
                p_set      = 0;
                bus.pronto = 1'b0;
            end else if (!active && bus.inicio) begin
                active     = 1;
                p_set      = 0;
                bus.pronto = 1'b0;
                ccnt       = (ctl_delay < 0) ? int'($urandom_range(10)) : ctl_delay;
                ini_cyc    = cyc;
            end else if (active) begin
                if (!bus.pronto) begin
                    if (ccnt == 0) begin
                        bus.pronto    = 1'b1;
                        bus.dp_result = dp_func(bus.dp_x);
                        p_cyc         = cyc;
                        p_set         = 1;
                    end else begin
                        ccnt--;
                    end
                end
            end else if (!bus.resp_valid && $urandom_range(3) == 0) begin
                bus.pronto    = 1'b1;
                bus.dp_result = W'($urandom);
            end else begin
                bus.pronto = 1'b0;
            end
        end
    end

    // One job: predict, optionally check start latency, drop req or hold off
    // the consumer, then wait for the handshake.
    task automatic run_job(input logic [N-1:0] mask, input logic [N*W-1:0] xv,
                           input int delay, input bit drop, input int hold,
                           input bit lat, input bit tmo);
        exp_t e;
        int   w;
        int   start_hs;
        ctl_delay = delay;
        bus.req_x = xv;
        bus.req   = mask;
        w         = rr_pick(model_last, mask);
        e.id      = w;
        e.data    = tmo ? '0 : dp_func(xv[w*W +: W]);
        e.err     = tmo;
        expq.push_back(e);
        model_last = w;
        start_hs   = hs_count;
        if (hold > 0) bp_hold = 1;
        if (lat) begin
            @(posedge clk); #1;
            check("arb_busy", 64'(bus.busy), 1);
            @(posedge clk); #1;
            check("start_inicio", 64'(bus.inicio), 1);
            check("start_grant", 64'(bus.grant), 64'(1) << w);
            check("start_dp_x", 64'(bus.dp_x), 64'(xv[w*W +: W]));
            @(posedge clk); #1;
            check("inicio_one_cycle", 64'(bus.inicio), 0);
        end
        if (drop) begin
            for (int t = 0; t < 20 && bus.grant == '0; t++) begin
                @(posedge clk); #1;
            end
            check("drop_grant_seen", 64'(bus.grant), 64'(1) << w);
            @(posedge clk); #1;
            bus.req = '0;
        end
        if (hold > 0) begin
            for (int t = 0; t < 200 && !bus.resp_valid; t++) begin
                @(posedge clk); #1;
            end
            check("bp_resp_seen", 64'(bus.resp_valid), 1);
            for (int t = 0; t < hold; t++) begin
                @(posedge clk); #1;
                check("bp_valid_held", 64'(bus.resp_valid), 1);
                check("bp_grant_held", 64'(bus.grant), 64'(1) << w);
            end
            bp_hold = 0;
        end
        for (int t = 0; t < 400 && hs_count == start_hs; t++) begin
            @(posedge clk); #1;
        end
        check("handshake_seen", 64'(hs_count != start_hs), 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_grant"}, 64'(bus.grant), 0);
        check({tag, "_busy"}, 64'(bus.busy), 0);
        check({tag, "_dp_x"}, 64'(bus.dp_x), 0);
        check({tag, "_inicio"}, 64'(bus.inicio), 0);
        check({tag, "_ctrl_clr"}, 64'(bus.ctrl_clr), 0);
        check({tag, "_resp_valid"}, 64'(bus.resp_valid), 0);
        check({tag, "_resp_id"}, 64'(bus.resp_id), 0);
        check({tag, "_resp_data"}, 64'(bus.resp_data), 0);
        check({tag, "_resp_err"}, 64'(bus.resp_err), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*W-1:0] xv;
        rst       = 1'b0;
        bus.req   = '0;
        bus.req_x = '0;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Round-robin with everybody requesting: ids 0,1,2,3,0.
        ready_pct = 100;
        for (int j = 0; j < 5; j++) begin
            xv = {$urandom};
            run_job(4'b1111, xv, -1, 0, 0, 0, 0);
        end

        // Single job on requester 1, operand 05, pronto after 8 cycles.
        xv = 32'h1122_0544;
        run_job(4'b0010, xv, 8, 0, 0, 1, 0);

        // Back-pressure: consumer holds off for 10 cycles.
        xv = {$urandom};
        run_job(4'b1010, xv, 3, 0, 10, 0, 0);

        // Requester drops req after grant; job still completes.
        xv = {$urandom};
        run_job(4'b0100, xv, 5, 1, 0, 0, 0);
        bus.req = '0;
        repeat (2) @(posedge clk);
        #1;

        // req vanishes before arbitration: back to idle, nothing issued.
        bus.req = 4'b0100;
        @(posedge clk); #1;
        check("abort_arb_busy", 64'(bus.busy), 1);
        bus.req = '0;
        @(posedge clk); #1;
        check("abort_grant", 64'(bus.grant), 0);
        check("abort_busy", 64'(bus.busy), 0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_inicio", 64'(bus.inicio), 0);

`ifdef CALC_TIMEOUT_EN
        xv = {$urandom};
        run_job(4'b0001, xv, 100000, 0, 0, 0, 1);
        check("timeout_clr_latency", 64'(clr_cyc - ini_cyc), 64'(TO + 1));
        xv = {$urandom};
        run_job(4'b0100, xv, TO - 1, 0, 0, 0, 0);
`else
        xv = {$urandom};
        run_job(4'b0001, xv, 40, 0, 0, 0, 0);
`endif

        // Randomized jobs with idle gaps, drops and random back-pressure.
        ready_pct = 60;
        for (int j = 0; j < 60; j++) begin
            logic [N-1:0] m;
            m  = N'($urandom_range(15, 1));
            xv = {$urandom};
            run_job(m, xv, -1, ($urandom_range(3) == 0), 0, 0, 0);
            if ($urandom_range(3) == 0) begin
                bus.req = '0;
                repeat ($urandom_range(4, 1)) @(posedge clk);
                #1;
            end
        end
        ready_pct = 100;

        // Asynchronous reset in WAIT, mid-cycle.
        bus.req   = 4'b1000;
        bus.req_x = {$urandom};
        ctl_delay = 12;
        for (int t = 0; t < 20 && !bus.inicio; t++) begin
            @(posedge clk); #1;
        end
        check("rst_test_inicio", 64'(bus.inicio), 1);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_outputs_zero("midreset");
        bus.req = '0;
        expq.delete();
        model_last = N - 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        xv = {$urandom};
        run_job(4'b0001, xv, 2, 0, 0, 1, 0);
        bus.req = '0;
        repeat (3) @(posedge clk);
        #1;
        check("end_idle_busy", 64'(bus.busy), 0);
        check("end_queue_empty", 64'(expq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
